// File: rtl/carregador_de_programa_if.sv
// Host load channel plus processor/instruction-memory bus of the program loader.
// slave is the loader's view; master is the host/processor/memory side.
interface carregador_de_programa_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              carga_ini;
    logic [ADDR_W-1:0] carga_base;
    logic [ADDR_W-1:0] carga_qtd;
    logic [DATA_W-1:0] dado_in;
    logic              dado_valid;
    logic              dado_ready;
    logic              carga_ocupado;
    logic              carga_fim;
    logic              erro;
    logic [DATA_W-1:0] soma;
    logic [ADDR_W-1:0] end_proc;
    logic              proc_resetn;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_end;
    logic [DATA_W-1:0] mem_dado;

    modport slave (
        input  carga_ini, carga_base, carga_qtd, dado_in, dado_valid, end_proc,
        output dado_ready, carga_ocupado, carga_fim, erro, soma,
               proc_resetn, mem_wr, mem_end, mem_dado
    );

    modport master (
        output carga_ini, carga_base, carga_qtd, dado_in, dado_valid, end_proc,
        input  dado_ready, carga_ocupado, carga_fim, erro, soma,
               proc_resetn, mem_wr, mem_end, mem_dado
    );
endinterface

// File: rtl/carregador_de_programa.sv
// Program loader: writes host words to instruction memory at zero latency per accepted word,
// holding the processor in reset; host backpressure via dado_ready (high only in CARGA).
module carregador_de_programa #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                       clock,
    input  logic                       reset,
    carregador_de_programa_if.slave    bus
);
    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CARGA  = 2'd1,
        LIBERA = 2'd2
    } estado_t;

    estado_t           estado, estado_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [ADDR_W-1:0] restante, restante_nxt;
    logic [DATA_W-1:0] soma, soma_nxt;
    logic              erro, erro_nxt;
    logic              proc_resetn, proc_resetn_nxt;
    logic [ADDR_W:0]   limite;
    logic              fora_faixa;
    logic              aceita;

    // One extra bit so base+qtd cannot wrap past the top of the address space.
    assign limite     = {1'b0, bus.carga_base} + {1'b0, bus.carga_qtd};
    assign fora_faixa = limite > (ADDR_W+1)'(DEPTH);
    assign aceita     = bus.dado_valid && (estado == CARGA);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado      <= OCIOSO;
            ptr         <= '0;
            restante    <= '0;
            soma        <= '0;
            erro        <= 1'b0;
            proc_resetn <= 1'b0;
        end else begin
            estado      <= estado_nxt;
            ptr         <= ptr_nxt;
            restante    <= restante_nxt;
            soma        <= soma_nxt;
            erro        <= erro_nxt;
            proc_resetn <= proc_resetn_nxt;
        end
    end

    always_comb begin
        estado_nxt      = estado;
        ptr_nxt         = ptr;
        restante_nxt    = restante;
        soma_nxt        = soma;
        erro_nxt        = erro;
        proc_resetn_nxt = proc_resetn;
        case (estado)
            OCIOSO: begin
                proc_resetn_nxt = 1'b1;
                if (bus.carga_ini) begin
                    if (fora_faixa) begin
                        erro_nxt = 1'b1;
                    end else begin
                        erro_nxt        = 1'b0;
                        ptr_nxt         = bus.carga_base;
                        restante_nxt    = bus.carga_qtd;
                        soma_nxt        = '0;
                        proc_resetn_nxt = 1'b0;
                        estado_nxt      = (bus.carga_qtd == '0) ? LIBERA : CARGA;
                    end
                end
            end
            CARGA: begin
                if (aceita) begin
                    ptr_nxt      = ptr + ADDR_W'(1);
                    restante_nxt = restante - ADDR_W'(1);
                    soma_nxt     = {soma[DATA_W-2:0], soma[DATA_W-1]} ^ bus.dado_in;
                    if (restante == ADDR_W'(1)) begin
                        estado_nxt = LIBERA;
                    end
                end
            end
            LIBERA: begin
                estado_nxt      = OCIOSO;
                proc_resetn_nxt = 1'b1;
            end
            default: begin
                estado_nxt = OCIOSO;
            end
        endcase
    end

    assign bus.dado_ready    = (estado == CARGA);
    assign bus.mem_wr        = aceita;
    assign bus.mem_end       = (estado == CARGA) ? ptr : bus.end_proc;
    assign bus.mem_dado      = bus.dado_in;
    assign bus.carga_ocupado = (estado != OCIOSO);
    assign bus.carga_fim     = (estado == LIBERA);
    assign bus.erro          = erro;
    assign bus.soma          = soma;
    assign bus.proc_resetn   = proc_resetn;
endmodule

// File: tb/tb_carregador_de_programa.sv
// Bench for the program loader: a transaction-level model checked every cycle,
// plus directed loads with hand-computed memory, checksum and timing expectations.
module tb_carregador_de_programa;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   c0 = 0;
    int   fim_count = 0;
    int   c;

    logic [15:0] mem [256];

    // Model state: what the loader is doing, described in load terms.
    bit          m_loading = 1'b0;
    bit          m_release = 1'b0;
    bit          m_run = 1'b0;
    bit          m_err = 1'b0;
    int          m_addr = 0;
    int          m_left = 0;
    logic [15:0] acc [$];

    carregador_de_programa_if bus ();

    carregador_de_programa dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    function automatic logic [15:0] checksum();
        logic [15:0] s;
        s = '0;
        foreach (acc[i]) s = {s[14:0], s[15]} ^ acc[i];
        return s;
    endfunction

    // Model update on each clock edge / asynchronous reset.
    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            m_loading = 1'b0; m_release = 1'b0; m_run = 1'b0; m_err = 1'b0;
            m_addr = 0; m_left = 0; acc.delete();
        end else if (m_release) begin
            m_release = 1'b0;
            m_run = 1'b1;
        end else if (m_loading) begin
            if (bus.dado_valid) begin
                acc.push_back(bus.dado_in);
                m_addr++;
                m_left--;
                if (m_left == 0) begin
                    m_loading = 1'b0;
                    m_release = 1'b1;
                end
            end
        end else begin
            m_run = 1'b1;
            if (bus.carga_ini) begin
                if (int'(bus.carga_base) + int'(bus.carga_qtd) > 256) begin
                    m_err = 1'b1;
                end else begin
                    m_err = 1'b0;
                    acc.delete();
                    m_run = 1'b0;
                    m_addr = int'(bus.carga_base);
                    m_left = int'(bus.carga_qtd);
                    if (m_left == 0) m_release = 1'b1;
                    else m_loading = 1'b1;
                end
            end
        end
    end

    // Instruction memory and cycle counter.
    initial forever begin
        @(posedge clock);
        cyc++;
        if (bus.mem_wr) mem[bus.mem_end[7:0]] = bus.mem_dado;
    end

    // Per-cycle comparison against the model.
    initial forever begin
        logic exp_wr;
        @(negedge clock);
        exp_wr = m_loading && bus.dado_valid;
        chk("proc_resetn", {31'b0, bus.proc_resetn}, {31'b0, m_run});
        chk("dado_ready", {31'b0, bus.dado_ready}, {31'b0, m_loading});
        chk("mem_wr", {31'b0, bus.mem_wr}, {31'b0, exp_wr});
        chk("mem_end", {16'b0, bus.mem_end}, {16'b0, (m_loading ? 16'(m_addr) : bus.end_proc)});
        if (exp_wr) chk("mem_dado", {16'b0, bus.mem_dado}, {16'b0, bus.dado_in});
        chk("carga_fim", {31'b0, bus.carga_fim}, {31'b0, m_release});
        chk("carga_ocupado", {31'b0, bus.carga_ocupado}, {31'b0, (m_loading | m_release)});
        chk("erro", {31'b0, bus.erro}, {31'b0, m_err});
        chk("soma", {16'b0, bus.soma}, {16'b0, checksum()});
        if (bus.carga_fim) fim_count++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end expected end before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [15:0] b, input logic [15:0] q);
        bus.carga_ini  = 1'b1;
        bus.carga_base = b;
        bus.carga_qtd  = q;
        tick();
        bus.carga_ini  = 1'b0;
        c0 = cyc;
    endtask

    task automatic send(input logic [15:0] w);
        bus.dado_valid = 1'b1;
        bus.dado_in    = w;
        tick();
        bus.dado_valid = 1'b0;
    endtask

    task automatic stall(input int n);
        bus.dado_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Returns the cycle number (edge of carga_ini = cycle 0) in which carga_fim is seen.
    task automatic wait_fim(output int cn);
        int k;
        k = 0;
        while (!bus.carga_fim && k < 12) begin
            tick();
            k++;
        end
        if (!bus.carga_fim) begin
            checks++;
            errors++;
            $display("FAIL fim_timeout: got no carga_fim expected carga_fim within 12 cycles");
        end
        cn = cyc - c0 + 1;
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 16'hDEAD;
        bus.carga_ini  = 1'b0;
        bus.carga_base = '0;
        bus.carga_qtd  = '0;
        bus.dado_in    = '0;
        bus.dado_valid = 1'b0;
        bus.end_proc   = 16'h0010;

        // Reset and idle
        repeat (2) @(posedge clock);
        #1;
        chk("rst_proc_resetn", {31'b0, bus.proc_resetn}, 32'd0);
        reset = 1'b0;
        tick();
        chk("first_edge_proc_resetn", {31'b0, bus.proc_resetn}, 32'd1);
        repeat (2) tick();
        chk("idle_mem_end", {16'b0, bus.mem_end}, 32'h0010);
        chk("idle_mem_wr", {31'b0, bus.mem_wr}, 32'd0);

        // Back-to-back load of three words
        start(16'h0020, 16'd3);
        chk("t1_proc_resetn_low", {31'b0, bus.proc_resetn}, 32'd0);
        send(16'h0001);
        chk("t1_soma1", {16'b0, bus.soma}, 32'h0001);
        send(16'h0002);
        chk("t1_soma2", {16'b0, bus.soma}, 32'h0000);
        send(16'h0004);
        chk("t1_soma3", {16'b0, bus.soma}, 32'h0004);
        wait_fim(c);
        chk("t1_fim_cycle", c, 32'd4);
        tick();
        chk("t1_proc_resetn_c5", {31'b0, bus.proc_resetn}, 32'd1);
        chk("t1_mem20", {16'b0, mem[8'h20]}, 32'h0001);
        chk("t1_mem21", {16'b0, mem[8'h21]}, 32'h0002);
        chk("t1_mem22", {16'b0, mem[8'h22]}, 32'h0004);
        chk("t1_soma_hold", {16'b0, bus.soma}, 32'h0004);

        // Same load with a two-cycle host stall
        start(16'h0020, 16'd3);
        send(16'h0001);
        stall(2);
        chk("t2_soma_stall", {16'b0, bus.soma}, 32'h0001);
        send(16'h0002);
        send(16'h0004);
        wait_fim(c);
        chk("t2_fim_cycle", c, 32'd6);
        chk("t2_soma", {16'b0, bus.soma}, 32'h0004);
        tick();

        // Out-of-range request, then a valid load clearing erro
        start(16'h00FF, 16'd2);
        chk("t3_erro", {31'b0, bus.erro}, 32'd1);
        chk("t3_ocupado", {31'b0, bus.carga_ocupado}, 32'd0);
        chk("t3_proc_resetn", {31'b0, bus.proc_resetn}, 32'd1);
        tick();
        chk("t3_erro_sticky", {31'b0, bus.erro}, 32'd1);
        start(16'h0000, 16'd1);
        chk("t3_erro_clear", {31'b0, bus.erro}, 32'd0);
        send(16'h1234);
        wait_fim(c);
        chk("t3_fim_cycle", c, 32'd2);
        tick();
        chk("t3_mem0", {16'b0, mem[8'h00]}, 32'h1234);

        // Load ending exactly at the top of memory
        start(16'h00FE, 16'd2);
        send(16'hAAAA);
        chk("t4_soma1", {16'b0, bus.soma}, 32'hAAAA);
        send(16'h5555);
        wait_fim(c);
        chk("t4_fim_cycle", c, 32'd3);
        chk("t4_erro", {31'b0, bus.erro}, 32'd0);
        tick();
        chk("t4_memFE", {16'b0, mem[8'hFE]}, 32'hAAAA);
        chk("t4_memFF", {16'b0, mem[8'hFF]}, 32'h5555);

        // Zero-length load: processor restart only
        start(16'h0040, 16'd0);
        wait_fim(c);
        chk("t5_fim_cycle", c, 32'd1);
        chk("t5_proc_resetn_low", {31'b0, bus.proc_resetn}, 32'd0);
        tick();
        chk("t5_proc_resetn_high", {31'b0, bus.proc_resetn}, 32'd1);
        chk("t5_no_write", {16'b0, mem[8'h40]}, 32'hDEAD);

        // Reset after two of four words
        start(16'h0010, 16'd4);
        send(16'h1111);
        send(16'h2222);
        reset = 1'b1;
        #1;
        chk("t6_rst_proc_resetn", {31'b0, bus.proc_resetn}, 32'd0);
        chk("t6_rst_soma", {16'b0, bus.soma}, 32'h0000);
        chk("t6_rst_ocupado", {31'b0, bus.carga_ocupado}, 32'd0);
        chk("t6_rst_ready", {31'b0, bus.dado_ready}, 32'd0);
        chk("t6_rst_mem_end", {16'b0, bus.mem_end}, 32'h0010);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("t6_fim_pulses", fim_count, 32'd5);
        chk("t6_mem10", {16'b0, mem[8'h10]}, 32'h1111);
        chk("t6_mem11", {16'b0, mem[8'h11]}, 32'h2222);
        chk("t6_mem12", {16'b0, mem[8'h12]}, 32'hDEAD);
        start(16'h0030, 16'd2);
        send(16'h0003);
        send(16'h0005);
        chk("t6_soma", {16'b0, bus.soma}, 32'h0003);
        wait_fim(c);
        chk("t6_fim_cycle", c, 32'd3);
        tick();
        chk("t6_mem30", {16'b0, mem[8'h30]}, 32'h0003);
        chk("t6_mem31", {16'b0, mem[8'h31]}, 32'h0005);
        chk("total_fim_pulses", fim_count, 32'd6);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
